// File: rtl/dram_queue_model.sv
// dram_queue_model: behavioural DRAM stand-in with an in-order request queue,
// a per-request stall counter (fixed or pseudo-random) and a single-entry read
// response register. Requests are serviced one at a time in acceptance order.
//
// Handshakes: a request transfers on a rising edge where req_en && req_rdy; a
// response transfers on a rising edge where rsp_en && rsp_rdy. A valid side
// never drops or changes its payload before the transfer edge.
module dram_queue_model #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 27,
    parameter int ADDR_LSB   = 3,
    parameter int QDEPTH     = 4,
    parameter int LAT_MIN    = 1,
    parameter int LAT_MAX    = 10,
    parameter int RANDOM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_en,
    output logic                  req_rdy,
    input  logic                  req_cmd,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_data,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_en,
    input  logic                  rsp_rdy,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int IDX_W     = ADDR_W - ADDR_LSB;
    localparam int NB        = DATA_W / 8;
    localparam int PTR_W     = $clog2(QDEPTH);
    localparam int OCC_W     = PTR_W + 1;
    localparam int CNT_W     = $clog2(LAT_MAX + 2);
    localparam int LAT_RANGE = LAT_MAX - LAT_MIN + 1;

    // ST_EXEC is never registered: it names the STALL edge on which the head executes.
    typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_EXEC} state_t;

    state_t state_q, state_d, phase;
    logic [CNT_W-1:0] cnt_q, cnt_d, lat_draw;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ_q;
    logic [31:0]      lfsr_q, lfsr_d;
    logic             accept, do_exec, exec_rd, exec_wr;

    // Queue storage and the modelled memory array (neither is reset)
    logic               q_cmd   [QDEPTH];
    logic [IDX_W-1:0]   q_idx   [QDEPTH];
    logic [DATA_W-1:0]  q_data  [QDEPTH];
    logic [NB-1:0]      q_wstrb [QDEPTH];
    logic [DATA_W-1:0]  mem     [2**IDX_W];

    logic               head_cmd;
    logic [IDX_W-1:0]   head_idx;
    logic [DATA_W-1:0]  head_data;
    logic [NB-1:0]      head_wstrb;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^req_addr[ADDR_LSB-1:0];

    assign head_cmd   = q_cmd[rd_ptr];
    assign head_idx   = q_idx[rd_ptr];
    assign head_data  = q_data[rd_ptr];
    assign head_wstrb = q_wstrb[rd_ptr];

    // Full is judged from registered occupancy only, so a same-edge pop never frees a slot early
    assign req_rdy = (occ_q < OCC_W'(QDEPTH));
    assign accept  = req_en && req_rdy;
    assign exec_rd = do_exec && head_cmd;
    assign exec_wr = do_exec && !head_cmd;

    // Stall length for the next request: uniform draw from the generator, or fixed LAT_MAX
    always_comb begin
        lat_draw = CNT_W'(LAT_MAX);
        if (RANDOM_LAT != 0)
            lat_draw = CNT_W'(32'(LAT_MIN) + (lfsr_q % 32'(LAT_RANGE)));
    end

    // xorshift32 step for the stall generator
    always_comb begin
        lfsr_d = lfsr_q;
        lfsr_d = lfsr_d ^ (lfsr_d << 13);
        lfsr_d = lfsr_d ^ (lfsr_d >> 17);
        lfsr_d = lfsr_d ^ (lfsr_d << 5);
    end

    // Engine next-state: IDLE loads the stall, STALL counts down then executes the head
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase   = state_q;
        case (state_q)
            ST_IDLE: begin
                if (occ_q != '0) begin
                    state_d = ST_STALL;
                    cnt_d   = lat_draw;
                end
            end
            ST_STALL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!head_cmd || !rsp_en || rsp_rdy) begin
                    phase   = ST_EXEC;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        do_exec = (phase == ST_EXEC);
    end

    // Engine, queue pointers, response register and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ_q    <= '0;
            rsp_en   <= 1'b0;
            rsp_data <= '0;
            rd_count <= '0;
            wr_count <= '0;
            lfsr_q   <= 32'h1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_exec)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, do_exec})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
            if (exec_rd) begin
                rsp_en   <= 1'b1;
                rsp_data <= mem[head_idx];
                rd_count <= rd_count + 1'b1;
            end else if (rsp_rdy) begin
                rsp_en <= 1'b0;
            end
            if (exec_wr)
                wr_count <= wr_count + 1'b1;
        end
    end

    // Capture an accepted request into the queue tail
    always_ff @(posedge clk) begin
        if (accept) begin
            q_cmd[wr_ptr]   <= req_cmd;
            q_idx[wr_ptr]   <= req_addr[ADDR_W-1:ADDR_LSB];
            q_data[wr_ptr]  <= req_data;
            q_wstrb[wr_ptr] <= req_wstrb;
        end
    end

    // Byte-masked memory write when a write request executes
    always_ff @(posedge clk) begin
        if (exec_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (head_wstrb[b])
                    mem[head_idx][8*b +: 8] <= head_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dram_queue_model.sv
// Bench for dram_queue_model: a fixed-latency instance (LAT_MAX=3) takes the
// directed vectors, a random-latency instance takes a long random sequence.
module tb_dram_queue_model;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 12;
  localparam int ADDR_LSB = 3;
  localparam int QDEPTH   = 4;
  localparam int NB       = DATA_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst_n, sel;
  logic              req_en, req_cmd, rsp_rdy;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [NB-1:0]     req_wstrb;

  logic              req_rdy_a, rsp_en_a, req_rdy_b, rsp_en_b;
  logic [DATA_W-1:0] rsp_data_a, rsp_data_b;
  logic [31:0]       rd_count_a, wr_count_a, rd_count_b, wr_count_b;

  logic              req_rdy_m, rsp_en_m;
  logic [DATA_W-1:0] rsp_data_m;
  logic [31:0]       rd_count_m, wr_count_m;

  assign req_rdy_m  = sel ? req_rdy_b  : req_rdy_a;
  assign rsp_en_m   = sel ? rsp_en_b   : rsp_en_a;
  assign rsp_data_m = sel ? rsp_data_b : rsp_data_a;
  assign rd_count_m = sel ? rd_count_b : rd_count_a;
  assign wr_count_m = sel ? wr_count_b : wr_count_a;

  dram_queue_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB), .QDEPTH(QDEPTH),
    .LAT_MIN(1), .LAT_MAX(3), .RANDOM_LAT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_en(req_en && !sel), .req_rdy(req_rdy_a), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .req_wstrb(req_wstrb),
    .rsp_en(rsp_en_a), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data_a),
    .rd_count(rd_count_a), .wr_count(wr_count_a)
  );

  dram_queue_model #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB), .QDEPTH(QDEPTH),
    .LAT_MIN(1), .LAT_MAX(10), .RANDOM_LAT(1)
  ) dut_rnd (
    .clk(clk), .rst_n(rst_n),
    .req_en(req_en && sel), .req_rdy(req_rdy_b), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .req_wstrb(req_wstrb),
    .rsp_en(rsp_en_b), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data_b),
    .rd_count(rd_count_b), .wr_count(wr_count_b)
  );

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_mem [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response transfer pops one expected word
  always @(negedge clk) begin
    if (rst_n && rsp_en_m && rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%h required=none", rsp_data_m);
      end else begin
        check("rsp_data", rsp_data_m, exp_q.pop_front());
      end
    end
  end

  // Drive one request and hold it until accepted; req_en stays high on return
  task automatic issue(input logic cmd, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input logic [NB-1:0] wstrb,
                       input logic [DATA_W-1:0] exp, output int acc_cyc, output int rd_at_acc);
    bit ok = 0;
    req_en = 1'b1; req_cmd = cmd; req_addr = addr; req_data = data; req_wstrb = wstrb;
    acc_cyc = 0; rd_at_acc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_rdy_m) begin
        rd_at_acc = int'(rd_count_m);
        if (cmd) exp_q.push_back(exp);
        @(posedge clk); #1;
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue1(input logic cmd, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [NB-1:0] wstrb,
                        input logic [DATA_W-1:0] exp);
    int a, r;
    issue(cmd, addr, data, wstrb, exp, a, r);
    req_en = 1'b0;
  endtask

  // Edges from the accept edge until a counter moves (execute edge)
  task automatic wait_done(output int n);
    logic [31:0] rd0, wr0;
    bit ok = 0;
    rd0 = rd_count_m; wr0 = wr_count_m; n = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      n++;
      if (rd_count_m != rd0 || wr_count_m != wr0) begin ok = 1; break; end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [DATA_W-1:0] D_A5  = {8{8'hA5}};
  localparam logic [DATA_W-1:0] D_11  = {8{8'h11}};
  localparam logic [DATA_W-1:0] D_22  = {8{8'h22}};
  localparam logic [DATA_W-1:0] D_MIX = 64'h1111_1111_1111_1122;
  localparam logic [DATA_W-1:0] D_33  = {8{8'h33}};
  localparam logic [DATA_W-1:0] D_77  = {8{8'h77}};

  initial begin
    int n, acc[5], rda[5], nrd, nwr;
    logic cmd;
    int w;
    logic [DATA_W-1:0] d, e;
    logic [NB-1:0] s;

    sel = 1'b0; rst_n = 1'b0; req_en = 1'b0; req_cmd = 1'b0;
    req_addr = '0; req_data = '0; req_wstrb = '0; rsp_rdy = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("rst_rsp_en", 64'(rsp_en_m), 64'd0);
    check("rst_rsp_data", rsp_data_m, 64'd0);
    check("rst_rd_count", 64'(rd_count_m), 64'd0);
    check("rst_wr_count", 64'(wr_count_m), 64'd0);
    check("rst_req_rdy", 64'(req_rdy_m), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read back, read latency with empty queue
    issue1(1'b0, 12'h040, D_A5, 8'hFF, '0); wait_done(n);
    check("wr_latency", 64'(n), 64'd5);
    issue1(1'b1, 12'h040, '0, '0, D_A5); wait_done(n);
    check("rd_latency", 64'(n), 64'd5);
    check("t24_rd_data", rsp_data_m, D_A5);
    wait_drain();
    check("t24_wr_count", 64'(wr_count_m), 64'd1);
    check("t24_rd_count", 64'(rd_count_m), 64'd1);

    // Partial byte-strobe write
    issue1(1'b0, 12'h080, D_11, 8'hFF, '0); wait_done(n);
    issue1(1'b0, 12'h080, D_22, 8'h01, '0); wait_done(n);
    issue1(1'b1, 12'h080, '0, '0, D_MIX); wait_done(n);
    check("t25_rd_data", rsp_data_m, D_MIX);
    wait_drain();
    check("t25_wr_count", 64'(wr_count_m), 64'd3);

    // Five back-to-back reads: queue fills after four, fifth waits for the first pop
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, (i % 2 == 0) ? 12'h040 : 12'h080, '0, '0,
            (i % 2 == 0) ? D_A5 : D_MIX, acc[i], rda[i]);
      if (i == 3) check("t26_rdy_low_full", 64'(req_rdy_m), 64'd0);
    end
    req_en = 1'b0;
    check("t26_fifth_gap", 64'(acc[4] - acc[0]), 64'd6);
    check("t26_pops_before_fifth", 64'(rda[4]), 64'd3);
    wait_drain();
    check("t26_rd_count", 64'(rd_count_m), 64'd7);

    // Backpressure: first response held, second read stalls until rsp_rdy
    rsp_rdy = 1'b0;
    issue(1'b1, 12'h040, '0, '0, D_A5, acc[0], rda[0]);
    issue(1'b1, 12'h080, '0, '0, D_MIX, acc[1], rda[1]);
    req_en = 1'b0;
    n = 0;
    while (!rsp_en_m && n < 50) begin @(posedge clk); #1; n++; end
    check("t27_rsp_seen", 64'(rsp_en_m), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t27_hold_en", 64'(rsp_en_m), 64'd1);
      check("t27_hold_data", rsp_data_m, D_A5);
    end
    check("t27_second_stalled", 64'(rd_count_m), 64'd8);
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    check("t27_second_en", 64'(rsp_en_m), 64'd1);
    check("t27_second_data", rsp_data_m, D_MIX);
    check("t27_rd_count", 64'(rd_count_m), 64'd9);
    wait_drain();
    @(posedge clk); #1;
    check("t27_rsp_cleared", 64'(rsp_en_m), 64'd0);
    check("t27_no_dup", 64'(exp_q.size()), 64'd0);

    // Reset during the stall of a queued write
    issue1(1'b0, 12'h100, D_33, 8'hFF, '0); wait_done(n);
    issue1(1'b0, 12'h100, D_77, 8'hFF, '0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("t28_rsp_en", 64'(rsp_en_m), 64'd0);
    check("t28_rsp_data", rsp_data_m, 64'd0);
    check("t28_rd_count", 64'(rd_count_m), 64'd0);
    check("t28_wr_count", 64'(wr_count_m), 64'd0);
    check("t28_req_rdy", 64'(req_rdy_m), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    check("t28_write_dropped", 64'(wr_count_m), 64'd0);
    issue1(1'b1, 12'h100, '0, '0, D_33); wait_done(n);
    wait_drain();
    check("t28_rd_count_after", 64'(rd_count_m), 64'd1);

    // Random latency instance against the memory model
    sel = 1'b1; rsp_rdy = 1'b1;
    @(posedge clk); #1;
    nrd = 0; nwr = 0;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      model_mem[i] = d;
      issue1(1'b0, 12'(i * 8), d, 8'hFF, '0); wait_done(n);
    end
    for (int i = 0; i < 1000; i++) begin
      cmd = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 15);
      d = {$urandom, $urandom};
      s = 8'($urandom_range(0, 255));
      e = model_mem[w];
      if (cmd) nrd++;
      else begin
        nwr++;
        for (int b = 0; b < NB; b++)
          if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
      end
      issue1(cmd, 12'(w * 8), d, s, e); wait_done(n);
      checks++;
      if (n < 3 || n > 12) begin
        failures++;
        $display("FAIL rnd_latency actual=%0d required=3..12", n);
      end
    end
    wait_drain();
    check("rnd_rd_count", 64'(rd_count_m), 64'(nrd));
    check("rnd_wr_count", 64'(wr_count_m), 64'(nwr + 16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_queue_model.md
DRAM_QUEUE_MODEL -- requirements
Module: dram_queue_model

Interface
REQ-001 SHALL have parameter DATA_W, default 128, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 27, request address width.
REQ-003 SHALL have parameter ADDR_LSB, default 3; word index = req_addr[ADDR_W-1:ADDR_LSB]; memory depth 2**(ADDR_W-ADDR_LSB) words.
REQ-004 SHALL have parameter QDEPTH, default 4, request queue entries (power of 2, >=2).
REQ-005 SHALL have parameters LAT_MIN, default 1, and LAT_MAX, default 10, stall cycle bounds, with 0 <= LAT_MIN <= LAT_MAX.
REQ-006 SHALL have parameter RANDOM_LAT, default 1; 1 = per-request stall uniform in [LAT_MIN,LAT_MAX]; 0 = fixed LAT_MAX.
REQ-007 Ports (one clock; reset is asynchronous and active-low):
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  asynchronous active-low reset
 req_en  in  1  request valid
 req_rdy  out  1  queue can accept a request
 req_cmd  in  1  1 = read, 0 = write
 req_addr  in  ADDR_W  byte address
 req_data  in  DATA_W  write data
 req_wstrb  in  DATA_W/8  write byte enables
 rsp_en  out  1  read response valid
 rsp_rdy  in  1  response accepted
 rsp_data  out  DATA_W  read data
 rd_count  out  32  completed reads, wraps
 wr_count  out  32  completed writes, wraps

Function
REQ-008 Request SHALL be accepted on an edge where req_en && req_rdy; cmd, addr, data, wstrb captured into queue tail.
REQ-009 req_rdy SHALL equal (queue occupancy < QDEPTH) from registered state; a same-edge pop SHALL NOT enable accept while full.
REQ-010 Requests SHALL be serviced strictly in acceptance order, one at a time; a read after a write to the same word SHALL return the written data.
REQ-011 Engine states: IDLE, STALL, EXEC.
REQ-012 IDLE: on an edge with queue non-empty, load cnt with stall L and go to STALL.
REQ-013 STALL: on each edge with cnt>0 decrement; on edge with cnt==0 go to EXEC behaviour same edge (execute head).
REQ-014 Execute write: for each byte b with wstrb[b]=1, RAM[idx] byte b <= data byte b; others unchanged; pop head; wr_count+1; go IDLE.
REQ-015 Execute read: only if rsp_en==0 or rsp_rdy==1 that edge; rsp_data <= RAM[idx], rsp_en <= 1, pop head, rd_count+1, go IDLE; otherwise hold in STALL with cnt==0 (stall on backpressure).
REQ-016 Resulting latency, empty idle queue, no backpressure: accept at edge k -> execute at edge k+2+L; rsp_en first high after that edge.
REQ-017 rsp_en/rsp_data SHALL remain stable while rsp_en && !rsp_rdy; rsp_en SHALL clear on an edge with rsp_rdy && no new read executing.
REQ-018 Simultaneous accept and pop SHALL keep occupancy unchanged; pointers wrap modulo QDEPTH.
REQ-019 Counters SHALL wrap 2**32-1 -> 0.
REQ-020 Random stall SHALL be drawn at IDLE->STALL transition; with LAT_MIN==LAT_MAX behaviour SHALL equal fixed mode.

Reset
REQ-021 rst_n low SHALL immediately force: queue empty, state IDLE, cnt 0, rsp_en 0, rsp_data 0, rd_count 0, wr_count 0; req_rdy 1 while held low only after first edge (registered occupancy 0).
REQ-022 Reset mid-operation SHALL drop all queued and in-service requests; an unexecuted write SHALL NOT modify RAM.
REQ-023 RAM contents SHALL NOT be cleared by reset.

Verification (RANDOM_LAT=0, LAT_MAX=3, QDEPTH=4 unless stated)
REQ-024 Write addr 0x40 data 0xA5..A5 wstrb all-1, then read 0x40 -> rsp_data 0xA5..A5, read rsp_en 5 cycles after its acceptance when queue empty; wr_count=1, rd_count=1.
REQ-025 Write 0x80 all 0x11, write 0x80 data 0x22.. wstrb 0x0001, read 0x80 -> low byte 0x22, other bytes 0x11.
REQ-026 Issue 5 back-to-back requests with rsp_rdy=1 -> req_rdy low after 4th accepted, 5th accepted only after first pop; responses in issue order.
REQ-027 Two reads with rsp_rdy=0 -> first rsp held stable, second stalls with cnt 0; raise rsp_rdy -> second data appears next edge, no response lost or duplicated.
REQ-028 Assert rst_n=0 during STALL of a queued write to 0x100 (prior content 0x33..) -> rsp_en 0, counters 0, later read 0x100 returns 0x33..
REQ-029 RANDOM_LAT=1, LAT_MIN=1, LAT_MAX=10, 1000 random reads/writes vs scoreboard -> all data matches, every latency in [3,12] when unstalled.
